// File: rtl/gtx_init_seq.sv
// GTX channel bring-up sequencer: GTXRESET -> RESETDONE -> core reset -> LANE_UP, with retries.
// Optional RUN-state LANE_UP debounce is enabled by defining GTX_INIT_LANE_DEBOUNCE_EN.
module gtx_init_seq #(
  parameter int RST_CYCLES      = 16,
  parameter int DONE_TIMEOUT    = 4095,
  parameter int CORE_RST_CYCLES = 64,
  parameter int LANE_TIMEOUT    = 65535,
  parameter int CNT_W           = 16
) (
  input  logic       REFCLK,
  input  logic       RESET,
  input  logic       TXPLLKDET,
  input  logic       GTXTEST1,
  input  logic       RESETDONE,
  input  logic       LANE_UP,
  output logic       GTXRESET,
  output logic       CORE_RESET,
  output logic       INIT_DONE,
  output logic [7:0] RETRY_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TEST,
    S_GTX_RST,
    S_WAIT_DONE,
    S_CORE_RST,
    S_WAIT_LANE,
    S_RUN
  } state_t;

  localparam logic [CNT_W-1:0] L_RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_CORE_LAST = CNT_W'(CORE_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_LANE_LAST = CNT_W'(LANE_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_timer;
  logic             r_seenTest;
  logic             w_retryInc;
  logic             w_laneLost;

`ifdef GTX_INIT_LANE_DEBOUNCE_EN
  // Counts consecutive low LANE_UP samples in RUN; the 8th low sample declares the lane lost.
  logic [2:0] r_laneLowCnt;

  always_ff @(posedge REFCLK) begin
    if (RESET)
      r_laneLowCnt <= '0;
    else if (r_state == S_RUN && w_nextState == S_RUN && !LANE_UP)
      r_laneLowCnt <= r_laneLowCnt + 3'd1;
    else
      r_laneLowCnt <= '0;
  end

  assign w_laneLost = !LANE_UP && (r_laneLowCnt == 3'd7);
`else
  assign w_laneLost = !LANE_UP;
`endif

  // PLL loss overrides everything; within a state, RESETDONE loss beats LANE_UP loss beats timeout.
  always_comb begin
    w_nextState = r_state;
    w_retryInc  = 1'b0;
    if (r_state != S_IDLE && !TXPLLKDET) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (TXPLLKDET) w_nextState = S_WAIT_TEST;
        S_WAIT_TEST: if (!GTXTEST1 && r_seenTest) w_nextState = S_GTX_RST;
        S_GTX_RST:   if (r_timer == L_RST_LAST) w_nextState = S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (RESETDONE) begin
            w_nextState = S_CORE_RST;
          end else if (r_timer == L_DONE_LAST) begin
            w_nextState = S_GTX_RST;
            w_retryInc  = 1'b1;
          end
        end
        S_CORE_RST: begin
          if (!RESETDONE)
            w_nextState = S_GTX_RST;
          else if (r_timer == L_CORE_LAST)
            w_nextState = S_WAIT_LANE;
        end
        S_WAIT_LANE: begin
          if (LANE_UP) begin
            w_nextState = S_RUN;
          end else if (r_timer == L_LANE_LAST) begin
            w_nextState = S_GTX_RST;
            w_retryInc  = 1'b1;
          end
        end
        S_RUN: begin
          if (!RESETDONE)
            w_nextState = S_GTX_RST;
          else if (w_laneLost)
            w_nextState = S_CORE_RST;
        end
        default: w_nextState = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state register.
  always_ff @(posedge REFCLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_seenTest <= 1'b0;
      RETRY_CNT  <= 8'd0;
      GTXRESET   <= 1'b0;
      CORE_RESET <= 1'b1;
      INIT_DONE  <= 1'b0;
    end else begin
      r_state <= w_nextState;

      if (w_nextState != r_state)
        r_timer <= '0;
      else if (r_state inside {S_GTX_RST, S_WAIT_DONE, S_CORE_RST, S_WAIT_LANE})
        r_timer <= r_timer + 1'b1;

      if (w_nextState != S_WAIT_TEST)
        r_seenTest <= 1'b0;
      else if (r_state == S_WAIT_TEST && GTXTEST1)
        r_seenTest <= 1'b1;

      if (w_retryInc && RETRY_CNT != 8'hFF)
        RETRY_CNT <= RETRY_CNT + 8'd1;

      GTXRESET   <= (w_nextState == S_GTX_RST);
      CORE_RESET <= !(w_nextState inside {S_WAIT_LANE, S_RUN});
      INIT_DONE  <= (w_nextState == S_RUN);
    end
  end

endmodule

// File: tb/tb_gtx_init_seq.sv
// Self-checking bench for gtx_init_seq: a phase/elapsed-time model checked every cycle plus
// hand-computed checkpoints. Honors GTX_INIT_LANE_DEBOUNCE_EN for the RUN lane-loss filter.
module tb_gtx_init_seq;

  localparam int RST_C   = 4;
  localparam int DONE_TO = 20;
  localparam int CORE_C  = 8;
  localparam int LANE_TO = 50;

`ifdef GTX_INIT_LANE_DEBOUNCE_EN
  localparam int DEB = 8;
`else
  localparam int DEB = 1;
`endif

  localparam int P_IDLE = 0, P_TEST = 1, P_GTX = 2, P_DONE = 3, P_CORE = 4, P_LANE = 5, P_RUN = 6;

  logic       REFCLK    = 1'b0;
  logic       RESET     = 1'b1;
  logic       TXPLLKDET = 1'b0;
  logic       GTXTEST1  = 1'b0;
  logic       RESETDONE = 1'b0;
  logic       LANE_UP   = 1'b0;
  logic       GTXRESET;
  logic       CORE_RESET;
  logic       INIT_DONE;
  logic [7:0] RETRY_CNT;

  int testsRun    = 0;
  int testsFailed = 0;

  gtx_init_seq #(
    .RST_CYCLES(RST_C), .DONE_TIMEOUT(DONE_TO), .CORE_RST_CYCLES(CORE_C),
    .LANE_TIMEOUT(LANE_TO), .CNT_W(16)
  ) dut (
    .REFCLK(REFCLK), .RESET(RESET), .TXPLLKDET(TXPLLKDET), .GTXTEST1(GTXTEST1),
    .RESETDONE(RESETDONE), .LANE_UP(LANE_UP), .GTXRESET(GTXRESET),
    .CORE_RESET(CORE_RESET), .INIT_DONE(INIT_DONE), .RETRY_CNT(RETRY_CNT)
  );

  always #5 REFCLK = ~REFCLK;

  // Model: the current phase, the clock count at which it began, and the rules for leaving it.
  int mPhase = P_IDLE, mStart = 0, mCyc = 0, mRetry = 0, mLow = 0;
  bit mSeen = 1'b0, modelValid = 1'b0;

  function automatic void enterPhase(input int p);
    mPhase = p;
    mStart = mCyc;
    mLow   = 0;
  endfunction

  function automatic void bumpRetry();
    if (mRetry < 255) mRetry++;
  endfunction

  always @(posedge REFCLK) begin
    int n;
    mCyc++;
    n = mCyc - mStart;
    if (RESET) begin
      mRetry = 0;
      mSeen  = 1'b0;
      enterPhase(P_IDLE);
    end else if (mPhase != P_IDLE && !TXPLLKDET) begin
      enterPhase(P_IDLE);
    end else begin
      case (mPhase)
        P_IDLE: begin
          mSeen = 1'b0;
          if (TXPLLKDET) enterPhase(P_TEST);
        end
        P_TEST: begin
          if (!GTXTEST1 && mSeen) begin mSeen = 1'b0; enterPhase(P_GTX); end
          else if (GTXTEST1) mSeen = 1'b1;
        end
        P_GTX:  if (n == RST_C) enterPhase(P_DONE);
        P_DONE: begin
          if (RESETDONE) enterPhase(P_CORE);
          else if (n == DONE_TO) begin bumpRetry(); enterPhase(P_GTX); end
        end
        P_CORE: begin
          if (!RESETDONE) enterPhase(P_GTX);
          else if (n == CORE_C) enterPhase(P_LANE);
        end
        P_LANE: begin
          if (LANE_UP) enterPhase(P_RUN);
          else if (n == LANE_TO) begin bumpRetry(); enterPhase(P_GTX); end
        end
        default: begin
          if (!RESETDONE) enterPhase(P_GTX);
          else if (!LANE_UP) begin
            mLow++;
            if (mLow >= DEB) enterPhase(P_CORE);
          end else mLow = 0;
        end
      endcase
    end
    modelValid = 1'b1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge REFCLK) begin
    if (modelValid) begin
      checkOutput("model GTXRESET", int'(GTXRESET), int'(mPhase == P_GTX));
      checkOutput("model CORE_RESET", int'(CORE_RESET), int'(mPhase != P_LANE && mPhase != P_RUN));
      checkOutput("model INIT_DONE", int'(INIT_DONE), int'(mPhase == P_RUN));
      checkOutput("model RETRY_CNT", int'(RETRY_CNT), mRetry);
    end
  end

  task automatic applyStimulus(input logic pll, input logic test, input logic done,
                               input logic lane, input logic rst, input int cycles);
    TXPLLKDET = pll;
    GTXTEST1  = test;
    RESETDONE = done;
    LANE_UP   = lane;
    RESET     = rst;
    repeat (cycles) @(negedge REFCLK);
  endtask

  function automatic logic sigSel(input int sel);
    case (sel)
      0:       return GTXRESET;
      1:       return CORE_RESET;
      default: return INIT_DONE;
    endcase
  endfunction

  task automatic waitFor(input string name, input int sel, input logic val,
                         input int budget, output int waited);
    waited = 0;
    while (sigSel(sel) !== val && waited < budget) begin
      @(negedge REFCLK);
      waited++;
    end
    if (sigSel(sel) !== val) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: timed out after %0d cycles, got %b, expected %b",
               name, budget, sigSel(sel), val);
    end
  endtask

  task automatic countHigh(input int sel, input int cycles, output int highs);
    highs = 0;
    repeat (cycles) begin
      @(negedge REFCLK);
      if (sigSel(sel) === 1'b1) highs++;
    end
  endtask

  task automatic measurePeriod(output int period);
    period = 0;
    while (GTXRESET === 1'b1 && period < 100) begin @(negedge REFCLK); period++; end
    while (GTXRESET !== 1'b1 && period < 100) begin @(negedge REFCLK); period++; end
  endtask

  initial begin
    int k;
    int p;
    repeat (3) @(negedge REFCLK);
    checkOutput("reset GTXRESET", int'(GTXRESET), 0);
    checkOutput("reset CORE_RESET", int'(CORE_RESET), 1);
    checkOutput("reset INIT_DONE", int'(INIT_DONE), 0);
    checkOutput("reset RETRY_CNT", int'(RETRY_CNT), 0);

    // Nominal bring-up.
    applyStimulus(1, 1, 0, 0, 0, 256);
    applyStimulus(1, 0, 0, 0, 0, 0);
    waitFor("gtxreset rise", 0, 1'b1, 5, k);
    k = 0;
    while (GTXRESET === 1'b1 && k < 20) begin @(negedge REFCLK); k++; end
    checkOutput("gtxreset width", k, 4);
    repeat (10) @(negedge REFCLK);
    applyStimulus(1, 0, 1, 0, 0, 0);
    k = 0;
    while (CORE_RESET !== 1'b0 && k < 30) begin @(negedge REFCLK); k++; end
    checkOutput("resetdone to core release", k, 9);
    repeat (30) @(negedge REFCLK);
    checkOutput("init_done before lane", int'(INIT_DONE), 0);
    applyStimulus(1, 0, 1, 1, 0, 1);
    checkOutput("init_done after lane", int'(INIT_DONE), 1);
    checkOutput("nominal retry", int'(RETRY_CNT), 0);

    // PLL loss in RUN, then a fresh test pulse is required.
    applyStimulus(0, 0, 1, 1, 0, 1);
    checkOutput("pll loss init_done", int'(INIT_DONE), 0);
    checkOutput("pll loss core_reset", int'(CORE_RESET), 1);
    applyStimulus(1, 0, 1, 1, 0, 0);
    countHigh(0, 40, k);
    checkOutput("no gtxreset without test", k, 0);
    applyStimulus(1, 1, 1, 1, 0, 4);
    applyStimulus(1, 0, 1, 1, 0, 0);
    waitFor("relock gtxreset", 0, 1'b1, 5, k);
    waitFor("relock init_done", 2, 1'b1, 40, k);

    // Short LANE_UP drop in RUN.
    applyStimulus(1, 0, 1, 0, 0, 1);
    checkOutput("lane drop3 init_done", int'(INIT_DONE), (DEB == 8) ? 1 : 0);
    checkOutput("lane drop3 core_reset", int'(CORE_RESET), (DEB == 8) ? 0 : 1);
    applyStimulus(1, 0, 1, 0, 0, 2);
    applyStimulus(1, 0, 1, 1, 0, 0);
    countHigh(0, 15, k);
    checkOutput("lane drop3 no gtxreset", k, 0);
    waitFor("lane drop3 recover", 2, 1'b1, 20, k);

    // Eight-cycle LANE_UP drop in RUN.
    applyStimulus(1, 0, 1, 0, 0, 7);
    checkOutput("lane drop8 cycle7", int'(INIT_DONE), (DEB == 8) ? 1 : 0);
    applyStimulus(1, 0, 1, 0, 0, 1);
    checkOutput("lane drop8 cycle8", int'(INIT_DONE), 0);
    applyStimulus(1, 0, 1, 1, 0, 0);
    waitFor("lane drop8 recover", 2, 1'b1, 20, k);

    // LANE_UP timeout.
    applyStimulus(1, 0, 1, 0, 1, 2);
    applyStimulus(1, 1, 1, 0, 0, 4);
    applyStimulus(1, 0, 1, 0, 0, 0);
    waitFor("lane wait entry", 1, 1'b0, 60, k);
    waitFor("lane timeout", 0, 1'b1, 80, k);
    checkOutput("lane timeout cycles", k, 50);
    checkOutput("lane timeout retry", int'(RETRY_CNT), 1);
    checkOutput("lane timeout core_reset", int'(CORE_RESET), 1);
    applyStimulus(1, 0, 1, 1, 0, 0);
    waitFor("lane late up", 2, 1'b1, 60, k);
    checkOutput("lane late retry", int'(RETRY_CNT), 1);

    // Reset during the second GTX_RST cycle.
    applyStimulus(1, 0, 0, 1, 0, 0);
    waitFor("resetdone loss gtxreset", 0, 1'b1, 5, k);
    @(negedge REFCLK);
    applyStimulus(1, 0, 0, 1, 1, 1);
    checkOutput("midreset gtxreset", int'(GTXRESET), 0);
    checkOutput("midreset core_reset", int'(CORE_RESET), 1);
    checkOutput("midreset retry", int'(RETRY_CNT), 0);
    checkOutput("midreset init_done", int'(INIT_DONE), 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    countHigh(0, 30, k);
    checkOutput("midreset no residual pulse", k, 0);

    // RESETDONE never rises: periodic retries up to saturation.
    applyStimulus(1, 0, 0, 0, 1, 2);
    applyStimulus(1, 1, 0, 0, 0, 4);
    applyStimulus(1, 0, 0, 0, 0, 0);
    waitFor("done timeout first pulse", 0, 1'b1, 10, k);
    for (int i = 1; i <= 3; i++) begin
      measurePeriod(p);
      checkOutput($sformatf("retry period %0d", i), p, 24);
      checkOutput($sformatf("retry count %0d", i), int'(RETRY_CNT), i);
    end
    for (int i = 4; i <= 300; i++) measurePeriod(p);
    checkOutput("retry saturated", int'(RETRY_CNT), 255);

    repeat (2) @(negedge REFCLK);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
